// File: rtl/msg_scroller_pkg.sv
// Shared constants, state encoding and index helper for the message scroller.
package msg_scroller_pkg;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int         MSG_DEPTH  = 16;
  localparam int         PAD_LEN    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } state_t;

  // Reduce idx into 0..n-1. idx is never 2n or more, so one subtract is enough.
  function automatic logic [4:0] wrap_idx(input logic [4:0] idx, input logic [4:0] n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/msg_scroller_tick_gen.sv
// Scroll-step timer: Tick is high on the last cycle of every TICK_DIV-cycle period.
module tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign Tick = ~Clear & (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      cnt_q <= '0;
    else if (Clear || Tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/msg_scroller.sv
// Four-digit scrolling text window over a 16-entry message buffer padded with four blanks.
module msg_scroller
  import msg_scroller_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25000000,
  parameter logic [7:0]  BLANK    = BLANK_CHAR
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       WrEn,
  input  logic [3:0] WrAddr,
  input  logic [7:0] WrData,
  input  logic       Start,
  input  logic       Stop,
  input  logic [4:0] Len,
  output logic [7:0] C1,
  output logic [7:0] C2,
  output logic [7:0] C3,
  output logic [7:0] C4,
  output logic       Busy,
  output logic       Wrap
);

  state_t     state_q, state_d;
  logic [7:0] msg_mem [MSG_DEPTH];
  logic [4:0] len_q;
  logic [4:0] pos_q;
  logic [4:0] len_clamp;
  logic [4:0] n_len;
  logic       start_go;
  logic       tick;
  logic       tick_clear;
  logic [4:0] idx [4];
  logic [7:0] win [4];

  assign len_clamp  = (Len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : Len;
  assign n_len      = len_q + 5'(PAD_LEN);
  assign start_go   = Start & ~Stop;
  assign tick_clear = (state_q != SCROLL) | Start;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (tick_clear),
    .Tick  (tick)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A Start with zero length never enters, and leaves, SCROLL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go && len_clamp != 5'd0) state_d = SCROLL;
      SCROLL:  if (Stop || (Start && len_clamp == 5'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the buffer must reset to BLANK, so it is built from flops rather than a RAM macro.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) msg_mem[i] <= BLANK;
    end else if (WrEn) begin
      msg_mem[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      len_q <= '0;
      pos_q <= '0;
      Wrap  <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      if (start_go) begin
        len_q <= len_clamp;
        pos_q <= '0;
      end else if (Stop) begin
        pos_q <= '0;
      end else if (state_q == SCROLL && tick) begin
        if (pos_q == n_len - 5'd1) begin
          pos_q <= '0;
          Wrap  <= 1'b1;
        end else begin
          pos_q <= pos_q + 5'd1;
        end
      end
    end
  end

  // Stream positions at or past len_q are the trailing blank padding.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = wrap_idx(pos_q + 5'(k), n_len);
      win[k] = (idx[k] < len_q) ? msg_mem[idx[k][3:0]] : BLANK;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      C1   <= BLANK;
      C2   <= BLANK;
      C3   <= BLANK;
      C4   <= BLANK;
      Busy <= 1'b0;
    end else begin
      Busy <= (state_q == SCROLL);
      if (state_q == SCROLL) begin
        C1 <= win[0];
        C2 <= win[1];
        C3 <= win[2];
        C4 <= win[3];
      end else begin
        C1 <= BLANK;
        C2 <= BLANK;
        C3 <= BLANK;
        C4 <= BLANK;
      end
    end
  end

endmodule

// File: tb/tb_msg_scroller.sv
// Directed bench for msg_scroller with TICK_DIV = 4 (one scroll step every 4 cycles).
module tb_msg_scroller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       WrEn;
  logic [3:0] WrAddr;
  logic [7:0] WrData;
  logic       Start;
  logic       Stop;
  logic [4:0] Len;
  logic [7:0] C1, C2, C3, C4;
  logic       Busy;
  logic       Wrap;

  int n_cmp = 0;
  int n_err = 0;

  msg_scroller #(
    .TICK_DIV (4),
    .BLANK    (8'h20)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .WrEn   (WrEn),
    .WrAddr (WrAddr),
    .WrData (WrData),
    .Start  (Start),
    .Stop   (Stop),
    .Len    (Len),
    .C1     (C1),
    .C2     (C2),
    .C3     (C3),
    .C4     (C4),
    .Busy   (Busy),
    .Wrap   (Wrap)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    cyc(1);
    WrEn = 1'b0;
  endtask

  // Returns at the falling edge right after the Start edge (E0).
  task automatic start_msg(input logic [4:0] l);
    Start = 1'b1; Len = l;
    cyc(1);
    Start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    Start = 1'b0; Stop = 1'b0; Len = '0;
    cyc(2);
    check("reset_c",    {C1, C2, C3, C4}, 32'h20202020);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_wrap", 32'(Wrap), 32'd0);
    Reset = 1'b0;
    cyc(3);
    check("idle_busy", 32'(Busy), 32'd0);

    // "HI", length 2: stream H I _ _ _ _, N = 6
    write_mem(4'd0, 8'h48);
    write_mem(4'd1, 8'h49);
    start_msg(5'd2);
    cyc(1);  check("hi_p0",   {C1, C2, C3, C4}, 32'h48492020);
             check("hi_busy", 32'(Busy), 32'd1);
    cyc(4);  check("hi_p1",   {C1, C2, C3, C4}, 32'h49202020);
    cyc(4);  check("hi_p2",   {C1, C2, C3, C4}, 32'h20202020);
    cyc(8);  check("hi_p4",   {C1, C2, C3, C4}, 32'h20204849);
    cyc(6);  check("hi_prewrap", 32'(Wrap), 32'd0);
    cyc(1);  check("hi_wrap",    32'(Wrap), 32'd1);
    cyc(1);  check("hi_postwrap", 32'(Wrap), 32'd0);
             check("hi_p0_again", {C1, C2, C3, C4}, 32'h48492020);

    // Restart on the very edge that would wrap again: Wrap suppressed, step timer cleared
    cyc(22);
    start_msg(5'd2);
             check("restart_nowrap", 32'(Wrap), 32'd0);
    cyc(1);  check("restart_p0", {C1, C2, C3, C4}, 32'h48492020);
    cyc(3);  check("restart_hold", {C1, C2, C3, C4}, 32'h48492020);
    cyc(1);  check("restart_p1", {C1, C2, C3, C4}, 32'h49202020);

    // Start and Stop together while scrolling: Stop wins
    Start = 1'b1; Stop = 1'b1; Len = 5'd2;
    cyc(1);
    Start = 1'b0; Stop = 1'b0;
    cyc(1);  check("stopwin_busy", 32'(Busy), 32'd0);
             check("stopwin_c",    {C1, C2, C3, C4}, 32'h20202020);
    cyc(8);  check("stopwin_stay", 32'(Busy), 32'd0);

    // Zero length never starts
    start_msg(5'd0);
    cyc(6);  check("len0_busy", 32'(Busy), 32'd0);
             check("len0_c",    {C1, C2, C3, C4}, 32'h20202020);

    // Length 20 clamps to 16: N = 20, wrap every 80 cycles
    start_msg(5'd20);
    cyc(1);  check("len20_p0",  {C1, C2, C3, C4}, 32'h48492020);
    cyc(68); check("len20_p17", {C1, C2, C3, C4}, 32'h20202048);
    cyc(10); check("len20_prewrap", 32'(Wrap), 32'd0);
    cyc(1);  check("len20_wrap1",   32'(Wrap), 32'd1);
    cyc(79); check("len20_mid",     32'(Wrap), 32'd0);
    cyc(1);  check("len20_wrap2",   32'(Wrap), 32'd1);
    Stop = 1'b1;
    cyc(1);
    Stop = 1'b0;
    cyc(1);

    // Buffer write inside the live window
    start_msg(5'd2);
    cyc(1);  check("wr_before", {C1, C2, C3, C4}, 32'h48492020);
    write_mem(4'd0, 8'h41);
    cyc(1);  check("wr_visible", {C1, C2, C3, C4}, 32'h41492020);
    cyc(2);  check("wr_p1",      {C1, C2, C3, C4}, 32'h49202020);
    cyc(16); check("wr_p5",      {C1, C2, C3, C4}, 32'h20414920);

    // Asynchronous reset mid-step at Pos = 3
    cyc(16); check("rst_p3", {C1, C2, C3, C4}, 32'h20202041);
    cyc(1);
    #2 Reset = 1'b1;
    #1;
    check("rst_async_c",    {C1, C2, C3, C4}, 32'h20202020);
    check("rst_async_busy", 32'(Busy), 32'd0);
    check("rst_async_wrap", 32'(Wrap), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    cyc(3);  check("rst_quiet", 32'(Busy), 32'd0);
    start_msg(5'd2);
    cyc(1);  check("rst_mem_blank", {C1, C2, C3, C4}, 32'h20202020);
             check("rst_rescroll",  32'(Busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
